spawn_in_writer: RTL



---
 rtl/spawn_in_writer_pkg.sv | 34 +++
 rtl/spawn_in_writer_if.sv | 34 +++
 rtl/spawn_in_writer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spawn_in_writer_pkg.sv
// Shared spawn-in queue geometry (the OmpSsManager constants) and small
// helpers used by the spawn-in writer.
package spawn_in_writer_pkg;

  localparam int ENTRY_VALID_OFFSET      = 63;
  localparam int SPAWN_IN_NOPICOS_OFFSET = 62;
  localparam int SPAWN_IN_ENTRY_WORDS    = 3;
  localparam int SPAWN_IN_IDX_W          = 10;
  localparam int SPAWN_IN_WORD_W         = 64;

  typedef logic [SPAWN_IN_IDX_W-1:0]  spawn_idx_t;
  typedef logic [SPAWN_IN_WORD_W-1:0] spawn_word_t;
  typedef logic [ENTRY_VALID_OFFSET-1:0] task_id_t;

  // Byte address of a 64-bit queue word: {19'd0, idx, 3'd0}
  function automatic logic [31:0] spawn_in_byte_addr(input spawn_idx_t idx);
    return {19'd0, idx, 3'd0};
  endfunction

  // Header word: valid bit set, NO_PICOS flag, everything else zero
  function automatic spawn_word_t spawn_in_header(input logic no_picos);
    spawn_word_t h;
    h = '0;
    h[ENTRY_VALID_OFFSET]      = 1'b1;
    h[SPAWN_IN_NOPICOS_OFFSET] = no_picos;
    return h;
  endfunction

  // Id words are 63-bit; the top bit is always stored as zero
  function automatic spawn_word_t spawn_in_id_word(input task_id_t id);
    return {1'b0, id};
  endfunction

endpackage

// File: rtl/spawn_in_writer_if.sv
// Notification stream (AXI-Stream, 64-bit) plus SpawnInQueue BRAM port B.
// master: the writer; slave: stream source and BRAM.
interface spawn_in_writer_if;

  logic [63:0] inStream_TDATA;
  logic        inStream_TVALID;
  logic        inStream_TREADY;
  logic        inStream_TLAST;

  logic [31:0] SpawnInQueue_Addr_B;
  logic        SpawnInQueue_EN_B;
  logic [7:0]  SpawnInQueue_WEN_B;
  logic [63:0] SpawnInQueue_Din_B;
  logic [63:0] SpawnInQueue_Dout_B;
  logic        SpawnInQueue_Clk_B;
  logic        SpawnInQueue_Rst_B;

  modport master (
    input  inStream_TDATA, inStream_TVALID, inStream_TLAST,
    output inStream_TREADY,
    output SpawnInQueue_Addr_B, SpawnInQueue_EN_B, SpawnInQueue_WEN_B,
    output SpawnInQueue_Din_B, SpawnInQueue_Clk_B, SpawnInQueue_Rst_B,
    input  SpawnInQueue_Dout_B
  );

  modport slave (
    output inStream_TDATA, inStream_TVALID, inStream_TLAST,
    input  inStream_TREADY,
    input  SpawnInQueue_Addr_B, SpawnInQueue_EN_B, SpawnInQueue_WEN_B,
    input  SpawnInQueue_Din_B, SpawnInQueue_Clk_B, SpawnInQueue_Rst_B,
    output SpawnInQueue_Dout_B
  );

endinterface

// File: rtl/spawn_in_writer.sv
// Spawn-in queue producer: receives 3-beat notifications, waits until the
// three target words are free, then writes task id, parent id and finally the
// header so an entry only becomes visible once complete.
// Optional build macro: SPAWN_IN_PROTOCOL_CHECK_EN (TLAST framing check and
// sticky protocolError output).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RECV_HDR  | waiting for flags beat (NO_PICOS)
// RECV_TID  | waiting for task id beat
// RECV_PTID | waiting for parent task id beat
// CHK_0..2  | issue reads of wIdx, wIdx+1, wIdx+2
// CHK_2..4  | fold returned valid bits into busy; CHK_4 decides retry/write
// WR_TID    | issue write of task id at wIdx+1
// WR_PTID   | issue write of parent id at wIdx+2
// WR_HDR    | issue header write at wIdx, advance wIdx by 3
//
// Address/WEN/Din are registered: whatever a state issues is on port B
// during the following cycle, so a read issued in CHK_0 returns data that
// CHK_2 samples.
module spawn_in_writer
  import spawn_in_writer_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  spawn_in_writer_if.master bus
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
  ,
  output logic              protocolError
`endif
);

  typedef enum logic [10:0] {
    RECV_HDR  = 11'b000_0000_0001,
    RECV_TID  = 11'b000_0000_0010,
    RECV_PTID = 11'b000_0000_0100,
    CHK_0     = 11'b000_0000_1000,
    CHK_1     = 11'b000_0001_0000,
    CHK_2     = 11'b000_0010_0000,
    CHK_3     = 11'b000_0100_0000,
    CHK_4     = 11'b000_1000_0000,
    WR_TID    = 11'b001_0000_0000,
    WR_PTID   = 11'b010_0000_0000,
    WR_HDR    = 11'b100_0000_0000
  } state_t;

  state_t      r_state;
  logic        r_tready;
  spawn_idx_t  r_widx;
  spawn_idx_t  r_addr_idx;
  logic [7:0]  r_wen;
  spawn_word_t r_din;
  logic        r_busy;
  logic        r_nopicos;
  task_id_t    r_tid;
  task_id_t    r_ptid;
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
  logic        r_proto_err;
`endif

  logic        w_beat;
  logic        w_rd_busy;
  spawn_idx_t  w_idx_p1;
  spawn_idx_t  w_idx_p2;
  logic        w_unused;

  assign w_beat    = bus.inStream_TVALID & r_tready;
  assign w_rd_busy = bus.SpawnInQueue_Dout_B[ENTRY_VALID_OFFSET];
  assign w_idx_p1  = r_widx + spawn_idx_t'(1);
  assign w_idx_p2  = r_widx + spawn_idx_t'(2);

  assign bus.inStream_TREADY     = r_tready;
  assign bus.SpawnInQueue_Addr_B = spawn_in_byte_addr(r_addr_idx);
  assign bus.SpawnInQueue_EN_B   = 1'b1;
  assign bus.SpawnInQueue_WEN_B  = r_wen;
  assign bus.SpawnInQueue_Din_B  = r_din;
  assign bus.SpawnInQueue_Clk_B  = ap_clk;
  assign bus.SpawnInQueue_Rst_B  = 1'b0;

`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
  assign protocolError = r_proto_err;
  assign w_unused = ^{bus.inStream_TDATA[63],
                      bus.SpawnInQueue_Dout_B[ENTRY_VALID_OFFSET-1:0]};
`else
  assign w_unused = ^{bus.inStream_TDATA[63], bus.inStream_TLAST,
                      bus.SpawnInQueue_Dout_B[ENTRY_VALID_OFFSET-1:0]};
`endif

  // Receive, free-check and write sequencing with registered port-B outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= RECV_HDR;
      r_tready   <= 1'b0;
      r_widx     <= '0;
      r_addr_idx <= '0;
      r_wen      <= 8'h00;
      r_din      <= '0;
      r_busy     <= 1'b0;
      r_nopicos  <= 1'b0;
      r_tid      <= '0;
      r_ptid     <= '0;
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
      r_proto_err <= 1'b0;
`endif
    end else begin
      r_wen      <= 8'h00;
      r_din      <= '0;
      r_addr_idx <= r_widx;
      unique case (r_state)
        RECV_HDR: begin
          r_tready <= 1'b1;
          if (w_beat) begin
            r_nopicos <= bus.inStream_TDATA[SPAWN_IN_NOPICOS_OFFSET];
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
            if (bus.inStream_TLAST) r_proto_err <= 1'b1;
            else                    r_state     <= RECV_TID;
`else
            r_state <= RECV_TID;
`endif
          end
        end
        RECV_TID: begin
          r_tready <= 1'b1;
          if (w_beat) begin
            r_tid <= bus.inStream_TDATA[ENTRY_VALID_OFFSET-1:0];
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
            if (bus.inStream_TLAST) begin
              r_proto_err <= 1'b1;
              r_state     <= RECV_HDR;
            end else begin
              r_state <= RECV_PTID;
            end
`else
            r_state <= RECV_PTID;
`endif
          end
        end
        RECV_PTID: begin
          r_tready <= 1'b1;
          if (w_beat) begin
            r_ptid   <= bus.inStream_TDATA[ENTRY_VALID_OFFSET-1:0];
            r_tready <= 1'b0;
            r_state  <= CHK_0;
`ifdef SPAWN_IN_PROTOCOL_CHECK_EN
            if (!bus.inStream_TLAST) r_proto_err <= 1'b1;
`endif
          end
        end
        CHK_0: begin
          r_addr_idx <= r_widx;
          r_state    <= CHK_1;
        end
        CHK_1: begin
          r_addr_idx <= w_idx_p1;
          r_state    <= CHK_2;
        end
        CHK_2: begin
          r_addr_idx <= w_idx_p2;
          r_busy     <= r_busy | w_rd_busy;
          r_state    <= CHK_3;
        end
        CHK_3: begin
          r_busy  <= r_busy | w_rd_busy;
          r_state <= CHK_4;
        end
        CHK_4: begin
          // Any set valid bit (possibly stale) means retry the whole check
          if (r_busy | w_rd_busy) begin
            r_busy  <= 1'b0;
            r_state <= CHK_0;
          end else begin
            r_state <= WR_TID;
          end
        end
        WR_TID: begin
          r_addr_idx <= w_idx_p1;
          r_wen      <= 8'hFF;
          r_din      <= spawn_in_id_word(r_tid);
          r_state    <= WR_PTID;
        end
        WR_PTID: begin
          r_addr_idx <= w_idx_p2;
          r_wen      <= 8'hFF;
          r_din      <= spawn_in_id_word(r_ptid);
          r_state    <= WR_HDR;
        end
        WR_HDR: begin
          r_addr_idx <= r_widx;
          r_wen      <= 8'hFF;
          r_din      <= spawn_in_header(r_nopicos);
          r_widx     <= r_widx + spawn_idx_t'(SPAWN_IN_ENTRY_WORDS);
          r_tready   <= 1'b1;
          r_state    <= RECV_HDR;
        end
        default: begin
          r_tready <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= RECV_HDR;
        end
      endcase
    end
  end

endmodule
